ws2812b_rx: RTL and testbench
=============================

# ws2812b_rx

Receiver/decoder for the single-wire WS2812B LED protocol, the counterpart of the team's WS2812B transmitter. Samples a WS2812B data line, classifies each high pulse as a 0 or 1 bit by width, assembles the first DATABITS bits of each frame into a word, and presents it on the reset/latch gap. Bits beyond the first DATABITS are passed through on `dout` for the next device in a chain. Used for loopback test of LED strings and for emulating a chain element in FPGA.

## Interface
- `DATABITS`, 24, bits per device word, MSB first on the wire.
- `CLKFREQ`, 10000000, clock frequency in Hz.
- Derived `THRESH` = floor(CLKFREQ*0.525e-6+0.5): high-width at or above this decodes as 1 (5 at 10 MHz).
- Derived `TRES_RX` = floor(CLKFREQ*50e-6+0.5): low-time that ends a frame (500 at 10 MHz).
- Derived `TMAXH` = floor(CLKFREQ*5e-6+0.5): high-time that is a line fault (50 at 10 MHz).

- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous and active-high.
- `din`  in  1  asynchronous WS2812B data line.
- `color`  out  DATABITS  last complete word received; holds until next valid frame.
- `valid`  out  1  one-cycle pulse when `color` updates.
- `error`  out  1  one-cycle pulse on incomplete frame or stuck-high line.
- `dout`  out  1  forwarded data line for downstream devices.

## Operation
- `din` passes a 2-flop synchronizer (reset to 0) giving `din_s`; all logic uses `din_s`.
- Counters: `lowcnt`, `highcnt` (32 bit, saturating), `bitcnt` (0..DATABITS, saturating at DATABITS), shift register `shreg[DATABITS-1:0]`, forward flag `fwd`.
- States: SYNC, LOW, HIGH.
- SYNC (after reset or fault): count consecutive low cycles; any high clears `lowcnt`. When `lowcnt` reaches TRES_RX -> LOW with `bitcnt`=0, `fwd`=0. Pulses seen in SYNC are ignored.
- LOW: `lowcnt` increments while `din_s`=0. Rising edge of `din_s` -> HIGH, `highcnt`=1, `lowcnt`=0.
- LOW latch: on the cycle `lowcnt` reaches TRES_RX (once per gap): if `bitcnt`==DATABITS, `color`<=`shreg`, pulse `valid`; if 1<=`bitcnt`<DATABITS, pulse `error`, `color` unchanged; if 0, no output. Then `bitcnt`=0, `fwd`=0, remain LOW.
- HIGH: `highcnt` increments while `din_s`=1. Falling edge -> LOW, `lowcnt`=1. Bit value = (`highcnt` >= THRESH). If `bitcnt`<DATABITS: `shreg`<=(`shreg`<<1)|bit, `bitcnt`++; if this makes `bitcnt`==DATABITS, set `fwd`. If `bitcnt` already DATABITS, bit is not stored.
- HIGH fault: `highcnt` reaching TMAXH pulses `error`, clears `bitcnt`, `fwd`, -> SYNC (needs full TRES_RX low before decoding again).
- `dout` = registered (`fwd` & `din_s`). `fwd` changes only while `din_s` is low, so forwarded pulses are never truncated or glitched; own bits never appear on `dout`.
- `rst` mid-frame: discard partial word, all outputs to reset values, state SYNC.

## Timing
- Reset values: `color`=0, `valid`=0, `error`=0, `dout`=0, state SYNC, all counters 0.
- `din` to `din_s`: 2 cycles. `din` to `dout`: 3 cycles; forwarded pulse widths preserved exactly.
- Bit decision on the cycle after `din_s` falls; high width measured in whole clock cycles.
- `valid`/`error` (incomplete frame): asserted TRES_RX+2 cycles after the last sampled falling edge of `din`, high exactly 1 cycle.
- Stuck-high `error`: TMAXH+2 cycles after `din` rises.
- `valid` and `error` never asserted in the same cycle.
- No minimum low time between bits beyond 1 cycle; minimum decodable high pulse 1 cycle (decodes 0).

## Test plan
- DATABITS=24, CLKFREQ=10 MHz, reset, 600 cycles low, frame 0xA5C30F with T0H=4/T0L=8/T1H=7/T1L=6, then 1000 low -> `color`=0xA5C30F, single `valid` pulse 502 cycles after last fall, `dout`=0 throughout, no `error`.
- 48-bit frame 0x123456 then 0xABCDEF -> `color`=0x123456; `dout` reproduces the 24 pulses of 0xABCDEF, each delayed 3 cycles with identical widths.
- 10 bits then 600 low -> one `error` pulse, no `valid`, `color` keeps previous value; next full frame 0x00FF00 -> `color`=0x00FF00.
- `din` held high 60 cycles -> `error` at cycle TMAXH+2 after rise; a frame sent after only 100 low cycles is ignored; after 500 low a frame 0x0F0F0F decodes.
- Width boundary: high 4 cycles -> bit 0, 5 cycles -> bit 1; all-4 frame -> 0x000000, all-5 frame -> 0xFFFFFF.
- `rst` asserted after 12 bits of a frame -> next cycle `color`=0, `valid`=0, `dout`=0; remaining bits ignored; after 500 low, frame 0x5A5A5A decodes.

Source files
------------

// File: rtl/ws2812b_rx.sv
// ws2812b_rx: WS2812B single-wire receiver. Decodes pulse widths into a word,
// publishes it on the latch gap, and forwards surplus bits on dout.
module ws2812b_rx #(
   parameter int DATABITS = 24,
   parameter int CLKFREQ  = 10000000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                din,
   output logic [DATABITS-1:0] color,
   output logic                valid,
   output logic                error,
   output logic                dout
);

   // Timing thresholds in clock cycles, rounded to nearest.
   localparam longint unsigned FREQ     = 64'(CLKFREQ);
   localparam longint unsigned THRESH_L = (FREQ * 64'd525 + 64'd500000000) / 64'd1000000000;
   localparam longint unsigned TRES_L   = (FREQ * 64'd50 + 64'd500000) / 64'd1000000;
   localparam longint unsigned TMAXH_L  = (FREQ * 64'd5 + 64'd500000) / 64'd1000000;

   localparam logic [31:0] THRESH  = 32'(THRESH_L);
   localparam logic [31:0] TRES_RX = 32'(TRES_L);
   localparam logic [31:0] TMAXH   = 32'(TMAXH_L);

   localparam int             BW   = $clog2(DATABITS + 1);
   localparam logic [BW-1:0]  FULL = BW'(DATABITS);

   typedef enum logic [1:0] {SYNC, LOW, HIGH} state_t;

   state_t              state, state_n;
   logic                din_m, din_s;
   logic [31:0]         lowcnt, lowcnt_n, highcnt, highcnt_n;
   logic [31:0]         lowcnt_inc, highcnt_inc;
   logic [BW-1:0]       bitcnt, bitcnt_n;
   logic [DATABITS-1:0] shreg, shreg_n, color_n;
   logic                fwd, fwd_n, valid_n, error_n, bit_val;

   // Saturating increments so a line idle for hours never wraps back to zero.
   assign lowcnt_inc  = (&lowcnt)  ? lowcnt  : lowcnt  + 32'd1;
   assign highcnt_inc = (&highcnt) ? highcnt : highcnt + 32'd1;

   // Two-flop synchronizer for the asynchronous data line, plus forwarded output.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value; blocking here would collapse the chain.
      if (rst) begin
         din_m <= 1'b0;
         din_s <= 1'b0;
         dout  <= 1'b0;
      end else begin
         din_m <= din;
         din_s <= din_m;
         dout  <= fwd & din_s;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= SYNC;
         lowcnt  <= '0;
         highcnt <= '0;
         bitcnt  <= '0;
         shreg   <= '0;
         fwd     <= 1'b0;
         color   <= '0;
         valid   <= 1'b0;
         error   <= 1'b0;
      end else begin
         state   <= state_n;
         lowcnt  <= lowcnt_n;
         highcnt <= highcnt_n;
         bitcnt  <= bitcnt_n;
         shreg   <= shreg_n;
         fwd     <= fwd_n;
         color   <= color_n;
         valid   <= valid_n;
         error   <= error_n;
      end
   end

   // Next-state logic: pulse measurement, bit assembly, latch and fault handling.
   always_comb begin
      // NOTE: every variable gets a default first, so no path leaves one
      // unassigned and no latch is inferred.
      state_n   = state;
      lowcnt_n  = lowcnt;
      highcnt_n = highcnt;
      bitcnt_n  = bitcnt;
      shreg_n   = shreg;
      fwd_n     = fwd;
      color_n   = color;
      valid_n   = 1'b0;
      error_n   = 1'b0;
      bit_val   = (highcnt >= THRESH);

      case (state)
         SYNC: begin
            // Wait for a full latch gap before trusting the line.
            if (din_s) begin
               lowcnt_n = '0;
            end else begin
               lowcnt_n = lowcnt_inc;
               if (lowcnt_inc == TRES_RX) begin
                  state_n  = LOW;
                  bitcnt_n = '0;
                  fwd_n    = 1'b0;
               end
            end
         end

         LOW: begin
            if (din_s) begin
               state_n   = HIGH;
               highcnt_n = 32'd1;
               lowcnt_n  = '0;
            end else begin
               lowcnt_n = lowcnt_inc;
               // Fires once per gap: afterwards lowcnt is past TRES_RX.
               if (lowcnt_inc == TRES_RX) begin
                  if (bitcnt == FULL) begin
                     color_n = shreg;
                     valid_n = 1'b1;
                  end else if (bitcnt != '0) begin
                     error_n = 1'b1;
                  end
                  bitcnt_n = '0;
                  fwd_n    = 1'b0;
               end
            end
         end

         HIGH: begin
            if (din_s) begin
               highcnt_n = highcnt_inc;
               if (highcnt_inc == TMAXH) begin
                  error_n  = 1'b1;
                  bitcnt_n = '0;
                  fwd_n    = 1'b0;
                  lowcnt_n = '0;
                  state_n  = SYNC;
               end
            end else begin
               state_n  = LOW;
               lowcnt_n = 32'd1;
               if (bitcnt != FULL) begin
                  shreg_n  = {shreg[DATABITS-2:0], bit_val};
                  bitcnt_n = bitcnt + BW'(1);
                  // Own word complete: later pulses in this frame belong downstream.
                  if (bitcnt == FULL - BW'(1)) fwd_n = 1'b1;
               end
            end
         end

         default: state_n = SYNC;
      endcase
   end

endmodule

// File: tb/tb_ws2812b_rx.sv
// tb_ws2812b_rx: scenario tasks with randomized pulse widths, checked against
// expectations computed from the protocol rules (width threshold, word length,
// gap timing, 3-cycle forward delay).
module tb_ws2812b_rx;
   localparam int DATABITS = 24;
   localparam int CLKFREQ  = 10000000;
   localparam int THRESH   = (CLKFREQ / 1000 * 525 + 500000) / 1000000;
   localparam int TRES_RX  = (CLKFREQ / 1000 * 50 + 500) / 1000;
   localparam int TMAXH    = (CLKFREQ / 1000 * 5 + 500) / 1000;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                din = 1'b0;
   logic [DATABITS-1:0] color;
   logic                valid, error, dout;

   ws2812b_rx #(.DATABITS(DATABITS), .CLKFREQ(CLKFREQ)) dut (
      .clk(clk), .rst(rst), .din(din),
      .color(color), .valid(valid), .error(error), .dout(dout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   typedef struct {int cyc; logic [DATABITS-1:0] word;} vev_t;
   typedef struct {int start; int width;} pulse_t;

   vev_t   valid_q[$];
   int     error_q[$];
   pulse_t dout_q[$];
   pulse_t exp_fwd_q[$];

   int last_rise = 0;
   int last_fall = 0;
   logic [DATABITS-1:0] exp_color = '0;

   // Output monitor: logs valid/error events and dout pulses, sampled on negedge.
   logic dout_prev = 1'b0;
   int   dout_start = 0;
   always @(negedge clk) begin
      vev_t   v;
      pulse_t p;
      if (valid === 1'b1) begin
         v.cyc = cyc; v.word = color;
         valid_q.push_back(v);
      end
      if (error === 1'b1) error_q.push_back(cyc);
      if (valid === 1'b1 || error === 1'b1) begin
         checks++;
         if (valid === 1'b1 && error === 1'b1) begin
            errors++;
            $display("FAIL valid_error_overlap: both high at cycle %0d", cyc);
         end
      end
      if (dout === 1'b1 && !dout_prev) dout_start = cyc;
      if (dout !== 1'b1 && dout_prev) begin
         p.start = dout_start; p.width = cyc - dout_start;
         dout_q.push_back(p);
      end
      dout_prev = (dout === 1'b1);
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   task automatic clear_logs();
      valid_q.delete(); error_q.delete(); dout_q.delete(); exp_fwd_q.delete();
   endtask

   task automatic hold_low(input int n);
      din = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // One high pulse of th cycles followed by tl low cycles.
   task automatic send_pulse(input int th, input int tl, input bit fwd_exp);
      pulse_t p;
      @(negedge clk); din = 1'b1; last_rise = cyc;
      repeat (th - 1) @(negedge clk);
      @(negedge clk); din = 1'b0; last_fall = cyc;
      repeat (tl - 1) @(negedge clk);
      if (fwd_exp) begin
         p.start = last_rise + 3; p.width = th;
         exp_fwd_q.push_back(p);
      end
   endtask

   // MSB-first word with fixed widths; pulses past DATABITS are expected on dout.
   task automatic send_word(input logic [63:0] w, input int n, input int t0h, input int t0l,
                            input int t1h, input int t1l, input bit decoded);
      for (int i = 0; i < n; i++) begin
         if (w[n-1-i]) send_pulse(t1h, t1l, decoded && i >= DATABITS);
         else          send_pulse(t0h, t0l, decoded && i >= DATABITS);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; din = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (color !== '0) begin errors++; $display("FAIL reset_color: got %h want 0", color); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
      checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error); end
      checks++; if (dout !== 1'b0) begin errors++; $display("FAIL reset_dout: got %b want 0", dout); end
      rst = 1'b0;
      clear_logs();
      hold_low(600);
      checks++; if (valid_q.size() + error_q.size() != 0) begin errors++;
         $display("FAIL reset_idle_events: got %0d events want 0", valid_q.size() + error_q.size()); end
   endtask

   task automatic test_basic_frame();
      clear_logs();
      send_word(64'hA5C30F, 24, 4, 8, 7, 6, 1'b1);
      hold_low(1000);
      exp_color = 24'hA5C30F;
      checks++; if (valid_q.size() != 1) begin errors++; $display("FAIL basic_valid_count: got %0d want 1", valid_q.size()); end
      if (valid_q.size() >= 1) begin
         checks++; if (valid_q[0].word !== 24'hA5C30F) begin errors++; $display("FAIL basic_word: got %h want a5c30f", valid_q[0].word); end
         checks++; if (valid_q[0].cyc != last_fall + TRES_RX + 2) begin errors++;
            $display("FAIL basic_valid_time: got %0d want %0d", valid_q[0].cyc - last_fall, TRES_RX + 2); end
      end
      checks++; if (error_q.size() != 0) begin errors++; $display("FAIL basic_error_count: got %0d want 0", error_q.size()); end
      checks++; if (dout_q.size() != 0) begin errors++; $display("FAIL basic_dout_pulses: got %0d want 0", dout_q.size()); end
      checks++; if (color !== 24'hA5C30F) begin errors++; $display("FAIL basic_color_hold: got %h want a5c30f", color); end
   endtask

   task automatic test_chain_forward();
      clear_logs();
      send_word({16'h0, 24'h123456, 24'hABCDEF}, 48, 4, 8, 7, 6, 1'b1);
      hold_low(600);
      exp_color = 24'h123456;
      checks++; if (valid_q.size() != 1) begin errors++; $display("FAIL chain_valid_count: got %0d want 1", valid_q.size()); end
      if (valid_q.size() >= 1) begin
         checks++; if (valid_q[0].word !== 24'h123456) begin errors++; $display("FAIL chain_word: got %h want 123456", valid_q[0].word); end
      end
      checks++; if (dout_q.size() != exp_fwd_q.size()) begin errors++;
         $display("FAIL chain_dout_count: got %0d want %0d", dout_q.size(), exp_fwd_q.size()); end
      for (int i = 0; i < dout_q.size() && i < exp_fwd_q.size(); i++) begin
         checks++;
         if (dout_q[i].start != exp_fwd_q[i].start || dout_q[i].width != exp_fwd_q[i].width) begin
            errors++;
            $display("FAIL chain_dout_pulse%0d: got start %0d width %0d want start %0d width %0d",
                     i, dout_q[i].start, dout_q[i].width, exp_fwd_q[i].start, exp_fwd_q[i].width);
         end
      end
   endtask

   task automatic test_incomplete();
      logic [63:0] w;
      clear_logs();
      w = 64'($urandom);
      send_word(w, 10, 4, 8, 7, 6, 1'b1);
      hold_low(600);
      checks++; if (error_q.size() != 1) begin errors++; $display("FAIL incomplete_error_count: got %0d want 1", error_q.size()); end
      if (error_q.size() >= 1) begin
         checks++; if (error_q[0] != last_fall + TRES_RX + 2) begin errors++;
            $display("FAIL incomplete_error_time: got %0d want %0d", error_q[0] - last_fall, TRES_RX + 2); end
      end
      checks++; if (valid_q.size() != 0) begin errors++; $display("FAIL incomplete_valid_count: got %0d want 0", valid_q.size()); end
      checks++; if (color !== exp_color) begin errors++; $display("FAIL incomplete_color_kept: got %h want %h", color, exp_color); end
      clear_logs();
      send_word(64'h00FF00, 24, 4, 8, 7, 6, 1'b1);
      hold_low(600);
      exp_color = 24'h00FF00;
      checks++; if (valid_q.size() != 1 || valid_q[0].word !== 24'h00FF00) begin errors++;
         $display("FAIL incomplete_recover: got %0d valids want one with 00ff00", valid_q.size()); end
   endtask

   task automatic test_stuck_high();
      int rise;
      clear_logs();
      @(negedge clk); din = 1'b1; rise = cyc;
      repeat (60) @(negedge clk);
      hold_low(100);
      send_word(64'($urandom), 24, 4, 8, 7, 6, 1'b0);
      hold_low(600);
      checks++; if (error_q.size() != 1) begin errors++; $display("FAIL stuck_error_count: got %0d want 1", error_q.size()); end
      if (error_q.size() >= 1) begin
         checks++; if (error_q[0] != rise + TMAXH + 2) begin errors++;
            $display("FAIL stuck_error_time: got %0d want %0d", error_q[0] - rise, TMAXH + 2); end
      end
      checks++; if (valid_q.size() != 0) begin errors++; $display("FAIL stuck_ignored_frame: got %0d valids want 0", valid_q.size()); end
      clear_logs();
      send_word(64'h0F0F0F, 24, 4, 8, 7, 6, 1'b1);
      hold_low(600);
      exp_color = 24'h0F0F0F;
      checks++; if (valid_q.size() != 1 || valid_q[0].word !== 24'h0F0F0F) begin errors++;
         $display("FAIL stuck_recover: got %0d valids want one with 0f0f0f", valid_q.size()); end
      checks++; if (error_q.size() != 0) begin errors++; $display("FAIL stuck_recover_error: got %0d want 0", error_q.size()); end
   endtask

   task automatic test_width_boundary();
      logic [DATABITS-1:0] w;
      // All pulses just under the threshold.
      clear_logs();
      for (int i = 0; i < DATABITS; i++) send_pulse(THRESH - 1, $urandom_range(1, 10), 1'b0);
      hold_low(600);
      checks++; if (valid_q.size() != 1 || valid_q[0].word !== 24'h000000) begin errors++;
         $display("FAIL width_all_short: got %0d valids want one with 000000", valid_q.size()); end
      // Mixed word at the boundary widths.
      clear_logs();
      w = DATABITS'($urandom);
      send_word(64'(w), 24, THRESH - 1, $urandom_range(1, 10), THRESH, $urandom_range(1, 10), 1'b1);
      hold_low(600);
      checks++; if (valid_q.size() != 1 || valid_q[0].word !== w) begin errors++;
         $display("FAIL width_mixed: got %0d valids want one with %h", valid_q.size(), w); end
      // All pulses exactly at the threshold.
      clear_logs();
      for (int i = 0; i < DATABITS; i++) send_pulse(THRESH, $urandom_range(1, 10), 1'b0);
      hold_low(600);
      exp_color = 24'hFFFFFF;
      checks++; if (valid_q.size() != 1 || valid_q[0].word !== 24'hFFFFFF) begin errors++;
         $display("FAIL width_all_long: got %0d valids want one with ffffff", valid_q.size()); end
   endtask

   task automatic test_rst_mid_frame();
      logic [63:0] w;
      clear_logs();
      w = 64'($urandom);
      send_word(w, 12, 4, 8, 7, 6, 1'b0);
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      checks++; if (color !== '0) begin errors++; $display("FAIL rst_mid_color: got %h want 0", color); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b want 0", valid); end
      checks++; if (dout !== 1'b0) begin errors++; $display("FAIL rst_mid_dout: got %b want 0", dout); end
      rst = 1'b0;
      exp_color = '0;
      send_word(w, 12, 4, 8, 7, 6, 1'b0);
      hold_low(600);
      checks++; if (valid_q.size() + error_q.size() != 0) begin errors++;
         $display("FAIL rst_mid_leftover: got %0d events want 0", valid_q.size() + error_q.size()); end
      clear_logs();
      send_word(64'h5A5A5A, 24, 4, 8, 7, 6, 1'b1);
      hold_low(600);
      exp_color = 24'h5A5A5A;
      checks++; if (valid_q.size() != 1 || valid_q[0].word !== 24'h5A5A5A) begin errors++;
         $display("FAIL rst_mid_recover: got %0d valids want one with 5a5a5a", valid_q.size()); end
   endtask

   // Random-length frames with random widths; expectations from the width
   // threshold and the frame-length rule.
   task automatic test_random_frames();
      for (int f = 0; f < 12; f++) begin
         int n, th;
         logic [DATABITS-1:0] w;
         clear_logs();
         n = $urandom_range(0, 40);
         w = '0;
         for (int i = 0; i < n; i++) begin
            th = ($urandom_range(0, 1) == 1) ? $urandom_range(THRESH, 20) : $urandom_range(1, THRESH - 1);
            if (i < DATABITS) w = {w[DATABITS-2:0], (th >= THRESH)};
            send_pulse(th, $urandom_range(1, 20), i >= DATABITS);
         end
         hold_low($urandom_range(520, 700));
         if (n >= DATABITS) begin
            exp_color = w;
            checks++; if (valid_q.size() != 1 || error_q.size() != 0) begin errors++;
               $display("FAIL rand%0d_events: got %0d valid %0d error want 1 valid", f, valid_q.size(), error_q.size()); end
            if (valid_q.size() >= 1) begin
               checks++; if (valid_q[0].word !== w || valid_q[0].cyc != last_fall + TRES_RX + 2) begin errors++;
                  $display("FAIL rand%0d_word: got %h at +%0d want %h at +%0d", f, valid_q[0].word,
                           valid_q[0].cyc - last_fall, w, TRES_RX + 2); end
            end
         end else if (n > 0) begin
            checks++; if (valid_q.size() != 0 || error_q.size() != 1) begin errors++;
               $display("FAIL rand%0d_events: got %0d valid %0d error want 1 error", f, valid_q.size(), error_q.size()); end
         end else begin
            checks++; if (valid_q.size() + error_q.size() != 0) begin errors++;
               $display("FAIL rand%0d_events: got %0d events want 0", f, valid_q.size() + error_q.size()); end
         end
         checks++; if (color !== exp_color) begin errors++; $display("FAIL rand%0d_color: got %h want %h", f, color, exp_color); end
         checks++;
         if (dout_q.size() != exp_fwd_q.size()) begin
            errors++;
            $display("FAIL rand%0d_dout_count: got %0d want %0d", f, dout_q.size(), exp_fwd_q.size());
         end else begin
            for (int i = 0; i < dout_q.size(); i++) begin
               if (dout_q[i].start != exp_fwd_q[i].start || dout_q[i].width != exp_fwd_q[i].width) begin
                  errors++;
                  $display("FAIL rand%0d_dout_pulse%0d: got %0d/%0d want %0d/%0d", f, i, dout_q[i].start,
                           dout_q[i].width, exp_fwd_q[i].start, exp_fwd_q[i].width);
                  break;
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_chain_forward();
      test_incomplete();
      test_stuck_high();
      test_width_boundary();
      test_rst_mid_frame();
      test_random_frames();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
